// File: rtl/layer_sequencer_pkg.sv
// rtl/layer_sequencer_pkg.sv - shared dimensions and FSM state type for the layer sequencer
`ifndef LAYER_SEQUENCER_DEFINES
`define LAYER_SEQUENCER_DEFINES
`define NUM_SPIKES 4
`define TIME_PERIOD 8
`define LOG_TIME_PERIOD 3
`define LOG_NEURONS_PER_LAYER 3
`endif

package layer_sequencer_pkg;

    localparam int NUM_SPIKES  = `NUM_SPIKES;
    localparam int TIME_PERIOD = `TIME_PERIOD;
    localparam int TIME_W      = `LOG_TIME_PERIOD + 1;
    localparam int NEURON_W    = `LOG_NEURONS_PER_LAYER + 1;
    localparam int SPIKES_W    = NUM_SPIKES * TIME_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_RUN    = 3'd2,
        ST_REPORT = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/layer_sequencer_gamma_timer.sv
// rtl/layer_sequencer_gamma_timer.sv - gamma-cycle time counter, active only while running
module gamma_timer
    import layer_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_l,
    input  logic              run,
    output logic [TIME_W-1:0] time_val,
    output logic              last
);

    assign last = run && (time_val == TIME_W'(TIME_PERIOD - 1));

    // Wraps to 0 after the last cycle so a back-to-back RUN starts clean.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            time_val <= '0;
        end else if (run && !last) begin
            time_val <= time_val + 1'b1;
        end else begin
            time_val <= '0;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - sequences samples through a spiking layer for training or testing runs
module layer_sequencer
    import layer_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_l,
    input  logic                start,
    input  logic                mode_train,
    input  logic [15:0]         num_samples,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [SPIKES_W-1:0] sample_spikes,
    output logic [SPIKES_W-1:0] spike_times,
    output logic [TIME_W-1:0]   time_val,
    output logic                training,
    input  logic [NEURON_W-1:0] winning_neuron,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [NEURON_W-1:0] result_neuron,
    output logic                busy,
    output logic                done
);

    seq_state_t  state;
    seq_state_t  state_nxt;
    logic [15:0] sample_cnt;
    logic [15:0] sample_target;
    logic [15:0] cnt_inc;
    logic        run;
    logic        last;
    logic        accept_start;

    assign cnt_inc      = sample_cnt + 16'd1;
    assign accept_start = (state == ST_IDLE) && start && (num_samples != 16'd0);

    gamma_timer u_gamma_timer (
        .clk      (clk),
        .rst_l    (rst_l),
        .run      (run),
        .time_val (time_val),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (num_samples != 16'd0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                if (sample_valid) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // The counter bumps on this same edge, so compare against its next value.
                if (last) begin
                    if (!training) begin
                        state_nxt = ST_REPORT;
                    end else begin
                        state_nxt = (cnt_inc == sample_target) ? ST_DONE : ST_FETCH;
                    end
                end
            end
            ST_REPORT: begin
                if (result_ready) begin
                    state_nxt = (sample_cnt == sample_target) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sample_ready = 1'b0;
        result_valid = 1'b0;
        done         = 1'b0;
        run          = 1'b0;
        busy         = (state != ST_IDLE);
        case (state)
            ST_FETCH:  sample_ready = 1'b1;
            ST_RUN:    run          = 1'b1;
            ST_REPORT: result_valid = 1'b1;
            ST_DONE:   done         = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            training      <= 1'b0;
            sample_target <= '0;
            sample_cnt    <= '0;
            spike_times   <= '0;
            result_neuron <= '0;
        end else begin
            if (accept_start) begin
                training      <= mode_train;
                sample_target <= num_samples;
            end
            if (sample_ready && sample_valid) begin
                spike_times <= sample_spikes;
            end
            if (last) begin
                sample_cnt <= cnt_inc;
                if (!training) begin
                    result_neuron <= winning_neuron;
                end
            end else if (state == ST_DONE) begin
                sample_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - directed vector bench for layer_sequencer
module tb_layer_sequencer
    import layer_sequencer_pkg::*;
;

    localparam int OBS_W = 5 + TIME_W + NEURON_W + SPIKES_W;

    logic                clk = 1'b0;
    logic                rst_l;
    logic                start;
    logic                mode_train;
    logic [15:0]         num_samples;
    logic                sample_valid;
    logic                sample_ready;
    logic [SPIKES_W-1:0] sample_spikes;
    logic [SPIKES_W-1:0] spike_times;
    logic [TIME_W-1:0]   time_val;
    logic                training;
    logic [NEURON_W-1:0] winning_neuron;
    logic                result_valid;
    logic                result_ready;
    logic [NEURON_W-1:0] result_neuron;
    logic                busy;
    logic                done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    layer_sequencer dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .start          (start),
        .mode_train     (mode_train),
        .num_samples    (num_samples),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .sample_spikes  (sample_spikes),
        .spike_times    (spike_times),
        .time_val       (time_val),
        .training       (training),
        .winning_neuron (winning_neuron),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_neuron  (result_neuron),
        .busy           (busy),
        .done           (done)
    );

    typedef struct packed {
        logic                start;
        logic                mode_train;
        logic [15:0]         ns;
        logic                sv;
        logic [SPIKES_W-1:0] spikes;
        logic [NEURON_W-1:0] win;
        logic                rr;
        logic [OBS_W-1:0]    exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [OBS_W-1:0] pk(input logic rdy, input logic bsy, input logic dn,
                                            input logic rv, input logic tr,
                                            input logic [TIME_W-1:0] tv,
                                            input logic [NEURON_W-1:0] rn,
                                            input logic [SPIKES_W-1:0] st);
        return {rdy, bsy, dn, rv, tr, tv, rn, st};
    endfunction

    function automatic logic [OBS_W-1:0] obs();
        return {sample_ready, busy, done, result_valid, training, time_val, result_neuron, spike_times};
    endfunction

    function automatic vec_t mk(input logic s, input logic m, input logic [15:0] ns, input logic sv,
                                input logic [SPIKES_W-1:0] sp, input logic [NEURON_W-1:0] w,
                                input logic rr, input logic [OBS_W-1:0] e);
        vec_t v;
        v.start = s; v.mode_train = m; v.ns = ns; v.sv = sv;
        v.spikes = sp; v.win = w; v.rr = rr; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; mode_train = 0; num_samples = 0; sample_valid = 0;
        sample_spikes = '0; winning_neuron = '0; result_ready = 0;
    endtask

    logic [SPIKES_W-1:0] spk[3];
    logic                rv_seen;
    logic                done_seen;

    initial begin
        spk[0] = 16'h1357; spk[1] = 16'h8ACE; spk[2] = 16'hF00D;
        idle_inputs();
        rst_l = 0;
        #1;
        chk("reset_outputs", 32'(obs()), 32'd0);
        step(); step();
        rst_l = 1;

        // Testing run of one sample with a delayed result accept.
        vecs.push_back(mk(1, 0, 16'd1, 0, 16'h0,    0, 0, pk(0, 0, 0, 0, 0, 0, 0, 16'h0)));
        vecs.push_back(mk(0, 0, 16'd0, 1, 16'hA5C3, 0, 0, pk(1, 1, 0, 0, 0, 0, 0, 16'h0)));
        for (int t = 0; t < 8; t++)
            vecs.push_back(mk(0, 0, 16'd0, 0, 16'h0, 5, 0, pk(0, 1, 0, 0, 0, TIME_W'(t), 0, 16'hA5C3)));
        vecs.push_back(mk(0, 0, 16'd0, 0, 16'h0, 3, 0, pk(0, 1, 0, 1, 0, 0, 5, 16'hA5C3)));
        vecs.push_back(mk(0, 0, 16'd0, 0, 16'h0, 3, 1, pk(0, 1, 0, 1, 0, 0, 5, 16'hA5C3)));
        vecs.push_back(mk(0, 0, 16'd0, 0, 16'h0, 0, 0, pk(0, 1, 1, 0, 0, 0, 5, 16'hA5C3)));
        vecs.push_back(mk(0, 0, 16'd0, 0, 16'h0, 0, 0, pk(0, 0, 0, 0, 0, 0, 5, 16'hA5C3)));
        for (int i = 0; i < vecs.size(); i++) begin
            step();
            start = vecs[i].start; mode_train = vecs[i].mode_train; num_samples = vecs[i].ns;
            sample_valid = vecs[i].sv; sample_spikes = vecs[i].spikes;
            winning_neuron = vecs[i].win; result_ready = vecs[i].rr;
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
        end
        step();
        idle_inputs();

        // Training, three samples, valid held high.
        start = 1; mode_train = 1; num_samples = 3; sample_valid = 1; rv_seen = 0;
        step();
        start = 0;
        for (int s = 0; s < 3; s++) begin
            sample_spikes = spk[s];
            chk($sformatf("trn_fetch%0d", s), {sample_ready, time_val}, {1'b1, TIME_W'(0)});
            for (int t = 0; t < 8; t++) begin
                step();
                if (result_valid) rv_seen = 1;
                chk($sformatf("trn_s%0d_t%0d", s, t), {sample_ready, training, time_val},
                    {1'b0, 1'b1, TIME_W'(t)});
            end
            chk($sformatf("trn_spikes%0d", s), 32'(spike_times), 32'(spk[s]));
            step();
        end
        chk("trn_done", {done, busy}, 2'b11);
        step();
        chk("trn_idle", {done, busy}, 2'b00);
        chk("trn_no_result_valid", 32'(rv_seen), 32'd0);
        idle_inputs();

        // Testing, two samples, result accepted after three waiting cycles.
        start = 1; num_samples = 2; sample_valid = 1;
        step();
        start = 0;
        for (int s = 0; s < 2; s++) begin
            winning_neuron = (s == 0) ? 4'd5 : 4'd2;
            sample_spikes = spk[s];
            step();
            repeat (7) step();
            step();
            winning_neuron = 4'd7;
            for (int w = 0; w < 3; w++) begin
                chk($sformatf("tst_wait%0d_%0d", s, w), {result_valid, result_neuron},
                    {1'b1, (s == 0) ? 4'd5 : 4'd2});
                step();
            end
            result_ready = 1;
            chk($sformatf("tst_accept%0d", s), {result_valid, result_neuron},
                {1'b1, (s == 0) ? 4'd5 : 4'd2});
            step();
            result_ready = 0;
        end
        chk("tst_done", {done, result_valid}, 2'b10);
        step();
        idle_inputs();

        // Zero-sample run.
        start = 1; num_samples = 0;
        step();
        start = 0;
        chk("zero_done", {done, sample_ready}, 2'b10);
        step();
        chk("zero_idle", {done, busy}, 2'b00);

        // Valid withheld while fetching.
        start = 1; mode_train = 1; num_samples = 1;
        step();
        start = 0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold%0d", i), {sample_ready, time_val}, {1'b1, TIME_W'(0)});
            step();
        end
        sample_valid = 1; sample_spikes = 16'h1234;
        step();
        sample_valid = 0;
        chk("hold_run", {sample_ready, busy, time_val, spike_times}, {2'b01, TIME_W'(0), 16'h1234});
        step();
        chk("hold_t1", 32'(time_val), 32'd1);
        repeat (7) step();
        chk("hold_done", 32'(done), 32'd1);
        step();
        idle_inputs();

        // start and mode changes mid-run are ignored.
        start = 1; mode_train = 1; num_samples = 1; sample_valid = 1; sample_spikes = spk[2];
        step();
        start = 0;
        step();
        sample_valid = 0;
        for (int t = 0; t < 8; t++) begin
            chk($sformatf("ign_t%0d", t), {training, time_val}, {1'b1, TIME_W'(t)});
            if (t == 2) begin start = 1; mode_train = 0; num_samples = 5; end
            if (t == 3) start = 0;
            step();
        end
        chk("ign_done", 32'(done), 32'd1);
        step();
        chk("ign_idle", {busy, training}, 2'b01);
        idle_inputs();

        // Reset at time_val=4 of the second sample, then a fresh run.
        start = 1; mode_train = 1; num_samples = 3; sample_valid = 1; sample_spikes = spk[0];
        step();
        start = 0;
        step();
        repeat (7) step();
        step();
        step();
        repeat (4) step();
        chk("rst_pre_tv", 32'(time_val), 32'd4);
        rst_l = 0;
        #1;
        chk("rst_async", 32'(obs()), 32'd0);
        done_seen = 0;
        step();
        rst_l = 1;
        repeat (3) begin
            step();
            if (done || busy) done_seen = 1;
        end
        chk("rst_no_done", 32'(done_seen), 32'd0);
        start = 1; mode_train = 1; num_samples = 1; sample_valid = 1; sample_spikes = spk[1];
        step();
        start = 0;
        step();
        sample_valid = 0;
        repeat (7) step();
        chk("fresh_t7", {time_val, spike_times}, {TIME_W'(7), spk[1]});
        step();
        chk("fresh_done", 32'(done), 32'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
